// File: rtl/snake_game_controller.sv
// Snake game controller: start/pause/over FSM, score-scaled game tick generator,
// and a small direction queue that buffers legal turns between ticks.
module snake_game_controller #(
    parameter int TICK_DIV    = 106470000,
    parameter int MIN_DIV     = 26617500,
    parameter int SPEEDUP     = 1000000,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    input  logic        i_Pause,
    input  logic [3:0]  i_Direction,
    input  logic        i_Kill,
    input  logic [15:0] i_Score,
    output logic        o_Tick,
    output logic [3:0]  o_Direction,
    output logic        o_GameReset,
    output logic [1:0]  o_State
);

    localparam int CW = $clog2(TICK_DIV + 1);
    localparam int QW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t state, state_next;

    logic       start_q, pause_q;
    logic [3:0] dir_q;
    logic       start_edge, pause_edge;
    logic [3:0] rise;

    logic [CW-1:0] counter, period;
    logic          run_step, fire;

    logic [3:0]    queue [QUEUE_DEPTH];
    logic [3:0]    queue_next [QUEUE_DEPTH];
    logic [QW-1:0] count, count_next, slot;
    logic [3:0]    ref_dir;
    logic          one_hot, push, pop;

    function automatic logic [CW-1:0] calc_period(input logic [15:0] score);
        logic [47:0] prod;
        prod = 48'(SPEEDUP) * {32'd0, score};
        if (prod > 48'(TICK_DIV - MIN_DIV))
            return CW'(MIN_DIV);
        return CW'(48'(TICK_DIV) - prod);
    endfunction

    function automatic logic [3:0] reverse_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    // Edge registers track the inputs even during reset, so held buttons stay silent.
    always_ff @(posedge i_Clk) begin
        start_q <= i_Start;
        pause_q <= i_Pause;
        dir_q   <= i_Direction;
    end

    assign start_edge = i_Start & ~start_q;
    assign pause_edge = i_Pause & ~pause_q;
    assign rise       = i_Direction & ~dir_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = RUN;
            RUN:     if (i_Kill) state_next = OVER;
                     else if (pause_edge) state_next = PAUSE;
            PAUSE:   if (pause_edge) state_next = RUN;
            OVER:    if (start_edge) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_GameReset = (state == IDLE);
        o_State     = state;
    end

    // Kill and pause both pre-empt the tick; the counter freezes on those cycles.
    assign run_step = (state == RUN) && !i_Kill && !pause_edge;
    assign fire     = run_step && (counter == period - CW'(1));

    always_comb begin
        ref_dir = o_Direction;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (count == QW'(i + 1)) ref_dir = queue[i];
    end

    always_comb begin
        one_hot    = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
        pop        = fire && (count != '0);
        push       = (state == RUN) && one_hot && (rise != ref_dir)
                     && (rise != reverse_dir(ref_dir))
                     && ((count < QW'(QUEUE_DEPTH)) || pop);
        slot       = count - QW'(pop);
        queue_next = queue;
        if (pop)
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) queue_next[i] = queue[i + 1];
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (push && (slot == QW'(i))) queue_next[i] = rise;
        count_next = count - QW'(pop) + QW'(push);
        if (state_next == IDLE || state_next == OVER)
            count_next = '0;
    end

    always_ff @(posedge i_Clk) begin
        queue <= queue_next;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            counter     <= '0;
            period      <= CW'(TICK_DIV);
            count       <= '0;
            o_Tick      <= 1'b0;
            o_Direction <= 4'b1000;
        end else begin
            o_Tick <= fire;
            count  <= count_next;
            if ((state == IDLE && start_edge) || fire) begin
                counter <= '0;
                period  <= calc_period(i_Score);
            end else if (run_step) begin
                counter <= counter + CW'(1);
            end
            if (state_next == IDLE)
                o_Direction <= 4'b1000;
            else if (pop)
                o_Direction <= queue[0];
        end
    end

endmodule

// File: doc/snake_game_controller.md
SNAKE_GAME_CONTROLLER -- requirements
Module: snake_game_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 106470000: base i_Clk cycles per game tick at score 0.
REQ-002 SHALL have parameter MIN_DIV, default 26617500: minimum tick period in cycles; MIN_DIV >= 2 and MIN_DIV <= TICK_DIV.
REQ-003 SHALL have parameter SPEEDUP, default 1000000: period reduction in cycles per score point.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 2: direction queue entries, from 1 to 4.
REQ-005 SHALL have port i_Clk, input, 1 bit: sole clock.
REQ-006 SHALL have port i_Rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_Start, input, 1 bit: debounced start/restart button level.
REQ-008 SHALL have port i_Pause, input, 1 bit: debounced pause button level.
REQ-009 SHALL have port i_Direction, input, 4 bits: debounced button levels [0]=up, [1]=down, [2]=left, [3]=right.
REQ-010 SHALL have port i_Kill, input, 1 bit: collision flag from the game logic.
REQ-011 SHALL have port i_Score, input, 16 bits: current unsigned score.
REQ-012 SHALL have port o_Tick, output, 1 bit: one-cycle game-step enable.
REQ-013 SHALL have port o_Direction, output, 4 bits: one-hot heading applied at each tick.
REQ-014 SHALL have port o_GameReset, output, 1 bit: holds the game logic in reset.
REQ-015 SHALL have port o_State, output, 2 bits: 00=IDLE, 01=RUN, 10=PAUSE, 11=OVER.

Function
REQ-016 SHALL detect button presses as 0->1 edges, comparing each input against its value registered on the previous cycle; a level held high SHALL produce exactly one event.
REQ-017 SHALL follow these FSM transitions: IDLE + start edge -> RUN; RUN + pause edge -> PAUSE; PAUSE + pause edge -> RUN; RUN + i_Kill=1 -> OVER; OVER + start edge -> IDLE.
REQ-018 SHALL resolve simultaneous events in RUN by priority: i_Kill, then pause edge, then tick; start edges in RUN and PAUSE SHALL be ignored.
REQ-019 SHALL assert o_GameReset combinationally from state, high exactly while state is IDLE.
REQ-020 SHALL run the period counter only in RUN; it SHALL hold its value in PAUSE and clear to 0 on entry to RUN from IDLE.
REQ-021 SHALL, in RUN, assert o_Tick for one cycle when counter == period-1, with the counter wrapping to 0 on that same edge.
REQ-022 SHALL compute the period as TICK_DIV - SPEEDUP*i_Score with at least 48-bit intermediate arithmetic, saturating to MIN_DIV whenever SPEEDUP*i_Score > TICK_DIV - MIN_DIV.
REQ-023 SHALL latch the period on RUN entry from IDLE and on every tick, so score changes never shorten a tick period already in progress.
REQ-024 SHALL capture direction presses only in RUN; a cycle with more than one rising bit SHALL be discarded.
REQ-025 SHALL compare each press against a reference heading: the queue tail if the queue is non-empty, otherwise o_Direction.
REQ-026 SHALL drop a press that equals the reference heading or is its reversal (up<->down, left<->right).
REQ-027 SHALL drop a press when the queue is full; the existing queue contents SHALL be unchanged.
REQ-028 SHALL, on a tick with a non-empty queue, pop the head into o_Direction on the same edge that raises o_Tick; with an empty queue, o_Direction SHALL be unchanged.
REQ-029 SHALL complete a push and a pop in the same cycle, including when the queue is full or empty, with the push validated against the pre-pop reference heading.
REQ-030 SHALL retain queue contents through PAUSE and flush the queue on entry to IDLE or OVER.
REQ-031 SHALL set o_Direction to 4'b1000 (right) on entry to IDLE.
REQ-032 SHALL keep o_Tick low in IDLE, PAUSE and OVER, and on the cycle i_Kill causes RUN -> OVER.

Reset
REQ-033 SHALL, on i_Rst=1 at a clock edge, set: state IDLE; o_Tick 0; o_Direction 4'b1000; o_GameReset 1; counter 0; queue empty; period TICK_DIV.
REQ-034 SHALL load the edge-detect registers with the current input values during reset, so buttons held through reset produce no event.
REQ-035 SHALL give reset priority over every other event, including mid-tick and mid-queue operation.

Verification
REQ-036 SHALL verify, with TICK_DIV=8, MIN_DIV=4, SPEEDUP=1, score 0: start pulse -> o_State=01 and o_GameReset=0 next cycle; o_Tick every 8 cycles with o_Direction=1000.
REQ-037 SHALL verify, in RUN heading right: press up, then left, then down before one tick -> queue holds up,left; down dropped as full; o_Direction=0001 at the next tick and 0100 at the following tick.
REQ-038 SHALL verify, heading right: press left -> dropped; press right -> dropped; press up and down in the same cycle -> dropped; o_Direction stays 1000.
REQ-039 SHALL verify: score 3 -> period 5; score 10 -> period 4 (saturated); a score change mid-period takes effect only after the next tick.
REQ-040 SHALL verify: pause at counter=5 -> no ticks for 20 cycles; unpause -> next tick 3 cycles later; i_Kill together with the tick cycle -> OVER, no tick.
REQ-041 SHALL verify: i_Rst asserted mid-RUN with a queued entry -> state IDLE, queue empty, o_Direction=1000, and no start event while i_Start is held high through reset.
